// File: rtl/pll_reset_sequencer.sv
// Pixel-clock PLL bring-up sequencer: resets the PLL, qualifies LOCK and gates the system reset.
// Runs only on the board reference clock and recovers automatically from loss of lock.
`timescale 1ns/1ps
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES   = 20,
  parameter int unsigned LOCK_TIMEOUT = 20000,
  parameter int unsigned LOCK_STABLE  = 2000,
  parameter int unsigned LOSS_FILTER  = 4,
  parameter int unsigned MAX_RETRIES  = 7
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       LOCK,
  input  logic       RETRY,
  output logic       PLL_RESETB,
  output logic       SYS_RESETN,
  output logic       FAULT,
  output logic [7:0] RELOCK_COUNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_QUALIFY   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST     = 16'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK sample that enters QUALIFY is the first stable sample.
  localparam logic [15:0] QUAL_LAST   = 16'(LOCK_STABLE - 2);
  localparam logic [15:0] LOSS_LAST   = 16'(LOSS_FILTER - 1);
  localparam logic [15:0] RETRY_LIMIT = 16'(MAX_RETRIES);

  state_t      state;
  logic [1:0]  sync;
  logic [15:0] cnt;
  logic [15:0] retries;
  logic        lock_s;

  assign lock_s = sync[1];
  assign STATE  = state;

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      sync         <= '0;
      state        <= ST_PLL_RST;
      cnt          <= '0;
      retries      <= '0;
      PLL_RESETB   <= 1'b0;
      SYS_RESETN   <= 1'b0;
      FAULT        <= 1'b0;
      RELOCK_COUNT <= '0;
    end else begin
      sync <= {sync[0], LOCK};
      unique case (state)
        ST_PLL_RST: begin
          if (cnt == RST_LAST) begin
            state      <= ST_WAIT_LOCK;
            cnt        <= '0;
            PLL_RESETB <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            cnt <= '0;
            if (LOCK_STABLE == 1) begin
              state      <= ST_RUN;
              SYS_RESETN <= 1'b1;
              retries    <= '0;
            end else begin
              state <= ST_QUALIFY;
            end
          end else if (cnt == TO_LAST) begin
            cnt        <= '0;
            retries    <= retries + 16'd1;
            PLL_RESETB <= 1'b0;
            if (retries + 16'd1 == RETRY_LIMIT) begin
              state <= ST_FAULT;
              FAULT <= 1'b1;
            end else begin
              state <= ST_PLL_RST;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_QUALIFY: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == QUAL_LAST) begin
            state      <= ST_RUN;
            cnt        <= '0;
            SYS_RESETN <= 1'b1;
            retries    <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_RUN: begin
          if (lock_s) begin
            cnt <= '0;
          end else if (cnt == LOSS_LAST) begin
            state      <= ST_PLL_RST;
            cnt        <= '0;
            retries    <= '0;
            PLL_RESETB <= 1'b0;
            SYS_RESETN <= 1'b0;
            if (RELOCK_COUNT != 8'hFF) RELOCK_COUNT <= RELOCK_COUNT + 8'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_FAULT: begin
          if (RETRY) begin
            state   <= ST_PLL_RST;
            cnt     <= '0;
            retries <= '0;
            FAULT   <= 1'b0;
          end
        end
        default: begin
          state      <= ST_PLL_RST;
          cnt        <= '0;
          PLL_RESETB <= 1'b0;
          SYS_RESETN <= 1'b0;
          FAULT      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: phase/streak model checked every cycle plus directed timing checks.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int RSTC = 4;
  localparam int TOUT = 50;
  localparam int STAB = 10;
  localparam int LOSS = 3;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       RESET = 1'b0;
  logic       LOCK = 1'b0;
  logic       RETRY = 1'b0;
  logic       PLL_RESETB, SYS_RESETN, FAULT;
  logic [7:0] RELOCK_COUNT;
  logic [2:0] STATE;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pll_reset_sequencer #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TOUT), .LOCK_STABLE(STAB),
    .LOSS_FILTER(LOSS), .MAX_RETRIES(MAXR)
  ) dut (
    .REFERENCECLK(clk), .RESET(RESET), .LOCK(LOCK), .RETRY(RETRY),
    .PLL_RESETB(PLL_RESETB), .SYS_RESETN(SYS_RESETN), .FAULT(FAULT),
    .RELOCK_COUNT(RELOCK_COUNT), .STATE(STATE)
  );

  always #10 clk = ~clk;

  // Model: phase number, cycles spent in phase, and lock streaks tracked separately.
  int m_phase = 0, m_age = 0, m_hi = 0, m_lo = 0, m_tries = 0, m_relocks = 0;
  bit m_sq0 = 0, m_sq1 = 0;

  always @(posedge clk or negedge RESET) begin
    int nxt;
    bit ls;
    if (!RESET) begin
      m_phase = 0; m_age = 0; m_hi = 0; m_lo = 0; m_tries = 0; m_relocks = 0;
      m_sq0 = 0; m_sq1 = 0;
    end else begin
      ls = m_sq1; m_sq1 = m_sq0; m_sq0 = LOCK;
      m_hi = (ls && (m_phase == 1 || m_phase == 2)) ? m_hi + 1 : 0;
      m_lo = (!ls && m_phase == 3) ? m_lo + 1 : 0;
      m_age++;
      nxt = m_phase;
      case (m_phase)
        0: if (m_age >= RSTC) nxt = 1;
        1: if (ls) nxt = (m_hi >= STAB) ? 3 : 2;
           else if (m_age >= TOUT) begin
             m_tries++;
             nxt = (m_tries >= MAXR) ? 4 : 0;
           end
        2: if (!ls) nxt = 1; else if (m_hi >= STAB) nxt = 3;
        3: if (m_lo >= LOSS) begin
             nxt = 0;
             if (m_relocks < 255) m_relocks++;
           end
        4: if (RETRY) nxt = 0;
        default: nxt = 0;
      endcase
      if (nxt == 3 || (m_phase == 3 && nxt == 0) || (m_phase == 4 && nxt == 0)) m_tries = 0;
      if (nxt != m_phase) m_age = 0;
      m_phase = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (PLL_RESETB !== (m_phase != 0 && m_phase != 4) || SYS_RESETN !== (m_phase == 3) ||
          FAULT !== (m_phase == 4) || RELOCK_COUNT !== 8'(m_relocks) || STATE !== 3'(m_phase)) begin
        errors++;
        $display("FAIL model t=%0t got pllb=%b sys=%b fault=%b rc=%0d st=%0d want pllb=%b sys=%b fault=%b rc=%0d st=%0d",
                 $time, PLL_RESETB, SYS_RESETN, FAULT, RELOCK_COUNT, STATE,
                 (m_phase != 0 && m_phase != 4), (m_phase == 3), (m_phase == 4), m_relocks, m_phase);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic bit sig(input int which);
    case (which)
      0: return PLL_RESETB;
      1: return SYS_RESETN;
      default: return FAULT;
    endcase
  endfunction

  // Edges until the selected output reaches val; -1 if the bound expires.
  task automatic edges_until(input string name, input int which, input bit val, input int bound,
                             output int n);
    n = 0;
    while (sig(which) != val) begin
      step(1);
      n++;
      if (n > bound) begin
        checks++; errors++;
        $display("FAIL %s: timeout after %0d cycles", name, bound);
        n = -1;
        return;
      end
    end
  endtask

  task automatic chk_reset_values(input string name);
    chk({name, "_pllb"}, PLL_RESETB, 0);
    chk({name, "_sys"}, SYS_RESETN, 0);
    chk({name, "_fault"}, FAULT, 0);
    chk({name, "_rc"}, RELOCK_COUNT, 0);
    chk({name, "_state"}, STATE, 0);
  endtask

  task automatic restart();
    RESET = 1'b0; LOCK = 1'b0;
    step(2);
    RESET = 1'b1;
  endtask

  initial begin
    int n;
    chk_en = 1'b1;
    step(3);
    chk_reset_values("reset");

    // Clean start
    RESET = 1'b1;
    edges_until("pllb_rise", 0, 1'b1, 20, n);
    chk("pllb_release_cycles", n, RSTC);
    step(20 - RSTC);
    LOCK = 1'b1;
    edges_until("clean_sys", 1, 1'b1, 100, n);
    chk("clean_sys_cycles", n, 2 + STAB);
    chk("clean_state_run", STATE, 3);
    RETRY = 1'b1; step(1); RETRY = 1'b0;
    step(3);
    chk("retry_ignored_in_run", STATE, 3);

    // Qualify glitch
    restart();
    step(10);
    LOCK = 1'b1; step(6);
    LOCK = 1'b0; step(1);
    LOCK = 1'b1;
    edges_until("glitch_sys", 1, 1'b1, 100, n);
    chk("glitch_sys_cycles", n, 12);

    // Timeout to fault
    restart();
    edges_until("fault_rise", 2, 1'b1, 400, n);
    chk("fault_cycles", n, 2 * (RSTC + TOUT));
    chk("fault_pllb", PLL_RESETB, 0);
    chk("fault_state", STATE, 4);
    step(5);
    chk("fault_held", FAULT, 1);
    RETRY = 1'b1; step(1); RETRY = 1'b0;
    chk("retry_fault_clear", FAULT, 0);
    chk("retry_state", STATE, 0);
    chk("retry_pllb_low", PLL_RESETB, 0);
    edges_until("retry_pllb", 0, 1'b1, 20, n);
    chk("retry_pllb_cycles", n, RSTC);

    // Loss in RUN
    LOCK = 1'b1;
    edges_until("loss_lock", 1, 1'b1, 100, n);
    LOCK = 1'b0; step(2); LOCK = 1'b1;
    step(6);
    chk("short_drop_sys", SYS_RESETN, 1);
    chk("short_drop_state", STATE, 3);
    LOCK = 1'b0;
    edges_until("loss_sys", 1, 1'b0, 20, n);
    chk("loss_sys_cycles", n, 2 + LOSS);
    chk("loss_rc", RELOCK_COUNT, 1);
    chk("loss_state", STATE, 0);
    LOCK = 1'b1;
    edges_until("relock", 1, 1'b1, 100, n);
    chk("relock_state", STATE, 3);

    // Saturation
    for (int i = 0; i < 259; i++) begin
      LOCK = 1'b0;
      edges_until("sat_drop", 1, 1'b0, 20, n);
      LOCK = 1'b1;
      edges_until("sat_relock", 1, 1'b1, 60, n);
    end
    chk("rc_saturated", RELOCK_COUNT, 255);

    // Async reset mid-RUN
    @(posedge clk); #3;
    RESET = 1'b0;
    #1;
    chk_reset_values("async");
    step(2);
    RESET = 1'b1;
    edges_until("async_pllb", 0, 1'b1, 20, n);
    chk("async_restart_cycles", n, RSTC);
    chk("async_rc_after", RELOCK_COUNT, 0);
    edges_until("async_relock", 1, 1'b1, 100, n);
    step(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
